mole_spawner: RTL
=================

// Module: mole_spawner
// PURPOSE
//  Generates the mole pattern for the whack-a-mole game: one lit hole at a time, pseudo-randomly placed.
//  Sits directly upstream of the whack detector and drives its 16-bit mole input.
//  Consumes the detector's registered whack flag to retire a mole early, and reports hit/miss pulses to scoring.
// PARAMETERS
//  TICK_DIV        50_000_000  clocks per game tick (prescaler period), >=1
//  GAP_TICKS       2           ticks with no mole between moles, >=1
//  LIFE_TICKS      8           ticks a mole stays up (initial value), >=1
//  MIN_LIFE_TICKS  2           floor for lifetime under speed-up, 1..LIFE_TICKS
//  LFSR_SEED       16'hACE1    LFSR reset value; a zero seed is replaced by 16'hACE1
// PORTS
//  clock_i     in   1   system clock
//  reset_i     in   1   synchronous reset, active-high
//  enable_i    in   1   game running; low = idle, board dark
//  whacked_i   in   1   level from whack detector: current mole was struck
//  mole_o      out  16  one-hot lit hole (all-zero when no mole), registered
//  hit_o       out  1   1-clock pulse: mole retired by whack
//  miss_o      out  1   1-clock pulse: mole expired unwhacked
//  level_o     out  4   hits since reset, saturating at 15 (feeds display)
// BEHAVIOUR
//  - Reset values: mole_o=0, hit_o=0, miss_o=0, level_o=0. State=S_IDLE, LFSR=seed, prescaler=0.
//  - Prescaler counts 0..TICK_DIV-1 and asserts tick on its last count.
//    It clears on every state transition, so each state lasts exactly N*TICK_DIV clocks.
//  - LFSR: 16-bit Fibonacci, x^16+x^14+x^13+x^11+1, shifting every clock when not in reset.
//  - FSM:
//    S_IDLE: mole_o=0. enable_i=1 -> S_GAP.
//    S_GAP: load gap_cnt=GAP_TICKS on entry and decrement on tick. At tick with gap_cnt==1 -> S_UP.
//    S_UP: on entry, idx=lfsr[3:0]. If idx==prev_idx, use idx+1 (mod 16). mole_o<=1<<idx, prev_idx<=idx.
//      life_cnt loads the current lifetime and decrements on tick.
//      whacked_i=1 -> hit_o pulse, level_o+1 (sat), mole_o<=0 -> S_GAP.
//      Else tick with life_cnt==1 -> miss_o pulse, mole_o<=0 -> S_GAP.
//  - mole_o changes on the same edge the state changes (no extra latency). Pulses are registered with that edge.
//  - Whack and expiry in the same cycle: the whack wins (hit_o only, never both).
//  - whacked_i in S_IDLE/S_GAP is ignored; no pulse, no count.
//  - enable_i low in any state -> S_IDLE next edge, mole_o=0. No hit/miss pulse. level_o is held.
//  - reset_i mid-mole: all outputs and state return to reset values on that edge. The reset value of prev_idx is 4'hF.
//  - Exactly zero or one bit of mole_o is set at all times.
// CONFIGURATION
//  Macro MOLE_SPEEDUP_EN:
//   defined: lifetime reload = max(LIFE_TICKS - level_o, MIN_LIFE_TICKS), evaluated on entry to S_UP.
//   undefined: lifetime reload is always LIFE_TICKS. MIN_LIFE_TICKS is unused.
// STRUCTURE
//  Package mole_pkg holds:
//   - state encoding S_IDLE/S_GAP/S_UP (2-bit)
//   - NUM_HOLES=16, HOLE_IDX_W=4
//   - LFSR tap mask 16'hB400
//   - default seed 16'hACE1
//  Sub-module mole_lfsr (clock_i, reset_i, seed, q[15:0]) isolates the zero-seed guard.
//  Prescaler, FSM and counters stay in mole_spawner.
// TESTING (TICK_DIV=4, GAP_TICKS=2, LIFE_TICKS=3, MIN_LIFE_TICKS=1, LFSR_SEED=16'h0001)
//  1. reset_i=1 for 5 clocks with enable_i=1 -> mole_o=0, hit_o=0, miss_o=0, level_o=0 throughout.
//  2. Release reset with enable_i=1 and no whack:
//     -> S_GAP for 8 clocks, then one mole_o bit set for exactly 12 clocks.
//     -> miss_o pulses 1 clock on the falling edge of mole_o, then 8 dark clocks.
//  3. whacked_i=1 for 1 clock, 5 clocks into the UP window:
//     -> mole_o=0 and hit_o=1 on the next edge, level_o=1.
//     -> the next mole's index differs from the previous one.
//  4. whacked_i=1 on the same clock the life counter expires -> hit_o=1, miss_o=0, level_o increments.
//  5. enable_i=0 mid-UP -> mole_o=0 next edge, no pulses, level_o held.
//     Re-enable -> 8 dark clocks before the next mole.
//  6. MOLE_SPEEDUP_EN defined, two hits:
//     -> the third mole stays up 4 clocks (1 tick).
//     -> without the macro the third mole stays up 12 clocks.

Source files
------------

// File: rtl/mole_pkg.sv
// Shared constants and state encoding for the whack-a-mole spawner.
package mole_pkg;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GAP  = 2'd1,
        S_UP   = 2'd2
    } state_t;

    localparam int          NUM_HOLES    = 16;
    localparam int          HOLE_IDX_W   = 4;
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
endpackage

// File: rtl/mole_lfsr.sv
// Free-running 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1); a zero seed
// would lock up, so it is swapped for the default seed.
module mole_lfsr
    import mole_pkg::*;
(
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic [15:0] seed,
    output logic [15:0] q
);
    logic [15:0] seed_safe;

    assign seed_safe = (seed == 16'd0) ? DEFAULT_SEED : seed;

    always_ff @(posedge clock_i) begin
        if (reset_i) q <= seed_safe;
        else         q <= {q[14:0], ^(q & LFSR_TAPS)};
    end
endmodule

// File: rtl/mole_spawner.sv
// Mole pattern generator: one lit hole at a time, tick-timed gap/up phases.
// Optional MOLE_SPEEDUP_EN shortens the mole lifetime as the level rises.
module mole_spawner
    import mole_pkg::*;
#(
    parameter int          TICK_DIV       = 50_000_000,
    parameter int          GAP_TICKS      = 2,
    parameter int          LIFE_TICKS     = 8,
    parameter int          MIN_LIFE_TICKS = 2,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        enable_i,
    input  logic        whacked_i,
    output logic [15:0] mole_o,
    output logic        hit_o,
    output logic        miss_o,
    output logic [3:0]  level_o
);
    localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int MAXT = (GAP_TICKS > LIFE_TICKS) ? GAP_TICKS : LIFE_TICKS;
    localparam int CW   = $clog2(MAXT + 1);

    state_t                state, state_n;
    logic [PW-1:0]         pre, pre_n;
    logic                  tick;
    logic [CW-1:0]         cnt, cnt_n;
    logic [CW-1:0]         life_reload;
    logic [HOLE_IDX_W-1:0] prev_idx, prev_n, idx;
    logic [15:0]           lfsr_q, mole_n;
    logic                  hit_n, miss_n;
    logic [3:0]            level_n;

    mole_lfsr u_lfsr (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .seed    (LFSR_SEED),
        .q       (lfsr_q)
    );

    assign tick = (pre == PW'(TICK_DIV - 1));
    // Never relight the same hole twice in a row.
    assign idx  = (lfsr_q[3:0] == prev_idx) ? lfsr_q[3:0] + 4'd1 : lfsr_q[3:0];

`ifdef MOLE_SPEEDUP_EN
    always_comb begin
        if (LIFE_TICKS - int'(level_o) > MIN_LIFE_TICKS)
            life_reload = CW'(LIFE_TICKS - int'(level_o));
        else
            life_reload = CW'(MIN_LIFE_TICKS);
    end
`else
    // MIN_LIFE_TICKS never exceeds LIFE_TICKS, so this is always LIFE_TICKS.
    assign life_reload = CW'((LIFE_TICKS > MIN_LIFE_TICKS) ? LIFE_TICKS : MIN_LIFE_TICKS);
`endif

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        mole_n  = mole_o;
        prev_n  = prev_idx;
        hit_n   = 1'b0;
        miss_n  = 1'b0;
        level_n = level_o;
        if (!enable_i) begin
            state_n = S_IDLE;
            mole_n  = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state_n = S_GAP;
                    cnt_n   = CW'(GAP_TICKS);
                end
                S_GAP: if (tick) begin
                    if (cnt == CW'(1)) begin
                        state_n = S_UP;
                        mole_n  = 16'd1 << idx;
                        prev_n  = idx;
                        cnt_n   = life_reload;
                    end else begin
                        cnt_n = cnt - CW'(1);
                    end
                end
                S_UP: begin
                    // Whack takes priority over a simultaneous expiry.
                    if (whacked_i) begin
                        state_n = S_GAP;
                        cnt_n   = CW'(GAP_TICKS);
                        mole_n  = '0;
                        hit_n   = 1'b1;
                        level_n = (level_o == 4'hF) ? level_o : level_o + 4'd1;
                    end else if (tick) begin
                        if (cnt == CW'(1)) begin
                            state_n = S_GAP;
                            cnt_n   = CW'(GAP_TICKS);
                            mole_n  = '0;
                            miss_n  = 1'b1;
                        end else begin
                            cnt_n = cnt - CW'(1);
                        end
                    end
                end
                default: begin
                    state_n = S_IDLE;
                    mole_n  = '0;
                end
            endcase
        end
    end

    // Prescaler restarts with every state change so phases are whole ticks.
    assign pre_n = ((state_n != state) || tick) ? '0 : pre + PW'(1);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state    <= S_IDLE;
            pre      <= '0;
            cnt      <= '0;
            prev_idx <= 4'hF;
            mole_o   <= '0;
            hit_o    <= 1'b0;
            miss_o   <= 1'b0;
            level_o  <= 4'd0;
        end else begin
            state    <= state_n;
            pre      <= pre_n;
            cnt      <= cnt_n;
            prev_idx <= prev_n;
            mole_o   <= mole_n;
            hit_o    <= hit_n;
            miss_o   <= miss_n;
            level_o  <= level_n;
        end
    end
endmodule
